issue_queue: RTL and testbench
==============================

Name: issue_queue

Overview:
- Out-of-order issue queue directly downstream of the rename stage.
- Captures renamed non-memory instructions (entry_allocate_issue / entry_issue) into an age-ordered, compacting buffer.
- Tracks source readiness against the rename busy vector plus the EXE busy-clear bypass.
- Dispatches the oldest ready entry to EXE, one per cycle; drives issue_halt back to rename for backpressure.

Parameters:
- DEPTH, 16, number of queue slots (power of two not required, minimum 4).
- CNT_W, 5, width of occupancy count (must hold 0..DEPTH).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-low reset.
- STALL  input  1  global stall; freezes queue, no alloc, no issue.
- FLUSH  input  1  synchronous flush; empties queue.
- entry_allocate_issue  input  1  rename allocate strobe (driven on negedge by rename).
- entry_issue  input  170  renamed instruction: control[169:82], instr[81:50], pc[49:18], map dest[17:12], map B[11:6], map A[5:0].
- busy  input  64  physical-register busy vector from rename.
- exe_busyclear_flag  input  1  EXE result writeback this cycle.
- exe_busyclear_reg  input  6  physical register being cleared.
- exe_stall  input  1  EXE cannot accept an instruction this cycle.
- issue_valid  output  1  registered; issue_entry valid.
- issue_entry  output  170  registered selected entry.
- issue_halt  output  1  combinational backpressure to rename.
- count  output  CNT_W  current occupancy.
- overflow_err  output  1  sticky; allocation arrived while full.

Behaviour:
- Reset (RESET low, any time, async):
  - All slot valid bits = 0; count = 0.
  - issue_valid = 0; issue_entry = 0; overflow_err = 0.
  - Takes effect mid-operation; any in-flight allocation is lost.
- Storage and ordering:
  - Slots 0..DEPTH-1; slot 0 is oldest.
  - Valid entries are always contiguous from slot 0 (compacting queue).
- Ready rule, per valid slot i:
  - ready_i = ~busy_eff[mapA_i] & ~busy_eff[mapB_i].
  - busy_eff = busy with bit exe_busyclear_reg forced to 0 when exe_busyclear_flag = 1 (same-cycle wakeup bypass).
- Select: lowest-index ready slot (oldest-first priority encoder).
- Each posedge, when RESET high:
  - FLUSH = 1: all valid bits cleared, count = 0, issue_valid = 0. Overrides allocate/issue that cycle. overflow_err is unchanged.
  - Else if STALL = 1: all state held, issue_valid = 0.
  - Else:
    - If a ready slot exists and exe_stall = 0:
      - issue_entry <= that slot; issue_valid <= 1.
      - Slots above it shift down by one.
    - Otherwise issue_valid <= 0; issue_entry holds its last value.
    - If entry_allocate_issue = 1 and the queue is not full (after accounting for removal):
      - Write entry_issue at the new tail: count when nothing issued, count-1 when one issued.
    - An entry allocated in cycle N is not eligible for selection until cycle N+1. Minimum latency from allocate to issue_valid is 2 posedges.
    - count_next = count + alloc_accepted - issued.
- Full handling:
  - issue_halt = (count >= DEPTH-1) | FLUSH. The one-slot margin covers the half-cycle rename pipeline.
  - If an allocation arrives while count = DEPTH and nothing issues: entry dropped, overflow_err <= 1 (sticky until reset).
  - Simultaneous issue and allocate at count = DEPTH is accepted; count stays at DEPTH.
- Empty: no issue; issue_valid = 0. Allocate into an empty queue writes slot 0.
- busy bit index 0 is treated like any other register (no special-casing).

Test Plan:
- Reset and idle:
  - RESET low mid-run with 5 entries held → next cycle count = 0, issue_valid = 0, issue_halt = 0, overflow_err = 0.
- Single in-order flow:
  - Allocate entry with mapA = 3, mapB = 4, busy = 0 → issue_valid = 1 exactly 2 posedges after allocate, issue_entry equals the allocated 170 bits, count returns to 0.
- Out-of-order selection:
  - Allocate E0 (mapA = 7, busy[7] = 1) then E1 (sources free) → E1 issues first.
  - Then assert exe_busyclear_flag = 1, reg = 7 → E0 issues that same cycle via the bypass; count = 0 afterwards.
- Backpressure:
  - Allocate 15 entries with sources busy (DEPTH = 16) → issue_halt = 1 at count = 15.
  - One further allocate → count = 16, overflow_err = 0.
  - A 17th allocate → dropped, overflow_err = 1.
- Flush and stall:
  - With 6 entries and ready sources, STALL = 1 for 3 cycles → no issue, count = 6.
  - FLUSH = 1 together with entry_allocate_issue = 1 → count = 0, issue_valid = 0.
- Compaction order:
  - Fill A, B, C, D (all ready), exe_stall = 1 for 2 cycles, then release → issue order A, B, C, D on consecutive cycles.

Source files
------------

// File: rtl/issue_queue.sv
// Out-of-order issue queue: age-ordered compacting buffer between rename and EXE.
// Picks the oldest entry whose sources are ready, issues at most one per cycle, and backpressures rename.
module issue_queue #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               STALL,
    input  logic               FLUSH,
    input  logic               entry_allocate_issue,
    input  logic [169:0]       entry_issue,
    input  logic [63:0]        busy,
    input  logic               exe_busyclear_flag,
    input  logic [5:0]         exe_busyclear_reg,
    input  logic               exe_stall,
    output logic               issue_valid,
    output logic [169:0]       issue_entry,
    output logic               issue_halt,
    output logic [CNT_W-1:0]   count,
    output logic               overflow_err
);

    localparam int ENTRY_W = 170;
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]   r_valid;
    logic [ENTRY_W-1:0] r_slot [DEPTH];
    logic [CNT_W-1:0]   r_count;
    logic               r_issue_valid;
    logic [ENTRY_W-1:0] r_issue_entry;
    logic               r_overflow;

    logic [63:0]        w_busy_eff;
    logic [DEPTH-1:0]   w_ready;
    logic               w_found;
    logic [IDX_W-1:0]   w_sel;
    logic               w_active;
    logic               w_full;
    logic               w_issue;
    logic               w_alloc;
    logic               w_drop;
    logic [CNT_W-1:0]   w_tail;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [DEPTH-1:0]   w_valid_nxt;
    logic [ENTRY_W-1:0] w_slot_nxt [DEPTH];

    // A register written back by EXE this cycle counts as free already.
    always_comb begin
        w_busy_eff = busy;
        if (exe_busyclear_flag) begin
            w_busy_eff[exe_busyclear_reg] = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ready[i] = r_valid[i]
                       & ~w_busy_eff[r_slot[i][5:0]]
                       & ~w_busy_eff[r_slot[i][11:6]];
        end
    end

    // Oldest-first priority encoder: scanning downward leaves the lowest ready index.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_found = 1'b1;
                w_sel   = IDX_W'(i);
            end
        end
    end

    assign w_active = ~FLUSH & ~STALL;
    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_issue  = w_active & w_found & ~exe_stall;
    assign w_alloc  = w_active & entry_allocate_issue & (~w_full | w_issue);
    assign w_drop   = w_active & entry_allocate_issue & w_full & ~w_issue;
    assign w_tail   = w_issue ? (r_count - CNT_W'(1)) : r_count;

    assign w_count_nxt = r_count + CNT_W'(w_alloc) - CNT_W'(w_issue);

    // Compaction: everything above the issued slot moves down one, then the new entry lands at the tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_valid_nxt[i] = r_valid[i];
            w_slot_nxt[i]  = r_slot[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (w_issue && (IDX_W'(i) >= w_sel)) begin
                w_valid_nxt[i] = r_valid[i+1];
                w_slot_nxt[i]  = r_slot[i+1];
            end
        end
        if (w_issue) begin
            w_valid_nxt[DEPTH-1] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_alloc && (w_tail == CNT_W'(i))) begin
                w_valid_nxt[i] = 1'b1;
                w_slot_nxt[i]  = entry_issue;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_valid       <= '0;
            r_count       <= '0;
            r_issue_valid <= 1'b0;
            r_issue_entry <= '0;
            r_overflow    <= 1'b0;
        end else if (FLUSH) begin
            r_valid       <= '0;
            r_count       <= '0;
            r_issue_valid <= 1'b0;
        end else if (STALL) begin
            r_issue_valid <= 1'b0;
        end else begin
            r_valid       <= w_valid_nxt;
            r_count       <= w_count_nxt;
            r_issue_valid <= w_issue;
            if (w_issue) begin
                r_issue_entry <= r_slot[w_sel];
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset: slot contents are only observed through r_valid.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            r_slot[i] <= w_slot_nxt[i];
        end
    end

    assign issue_valid  = r_issue_valid;
    assign issue_entry  = r_issue_entry;
    assign count        = r_count;
    assign overflow_err = r_overflow;
    assign issue_halt   = (r_count >= CNT_W'(DEPTH - 1)) | FLUSH;

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: stimulus pushes expected issue order, a monitor pops on issue_valid.
module tb_issue_queue;

    localparam int DEPTH = 16;
    localparam int CNT_W = 5;

    logic             CLK;
    logic             RESET;
    logic             STALL;
    logic             FLUSH;
    logic             entry_allocate_issue;
    logic [169:0]     entry_issue;
    logic [63:0]      busy;
    logic             exe_busyclear_flag;
    logic [5:0]       exe_busyclear_reg;
    logic             exe_stall;
    logic             issue_valid;
    logic [169:0]     issue_entry;
    logic             issue_halt;
    logic [CNT_W-1:0] count;
    logic             overflow_err;

    int n_vec = 0;
    int n_err = 0;
    logic [169:0] exp_q [$];

    issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .STALL                (STALL),
        .FLUSH                (FLUSH),
        .entry_allocate_issue (entry_allocate_issue),
        .entry_issue          (entry_issue),
        .busy                 (busy),
        .exe_busyclear_flag   (exe_busyclear_flag),
        .exe_busyclear_reg    (exe_busyclear_reg),
        .exe_stall            (exe_stall),
        .issue_valid          (issue_valid),
        .issue_entry          (issue_entry),
        .issue_halt           (issue_halt),
        .count                (count),
        .overflow_err         (overflow_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [169:0] mk(input logic [7:0] tag, input logic [5:0] a, input logic [5:0] b);
        logic [169:0] e;
        e          = '0;
        e[169:82]  = {tag, 72'h5A5A_0000_0000_0000_A5, tag};
        e[81:50]   = {24'hC0FFEE, tag};
        e[49:18]   = {24'h000400, tag};
        e[17:12]   = tag[5:0];
        e[11:6]    = b;
        e[5:0]     = a;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [169:0] act, input logic [169:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_alloc(input logic en, input logic [169:0] e);
        @(negedge CLK);
        entry_allocate_issue = en;
        entry_issue          = e;
    endtask

    // Monitor: every issued entry must match the head of the expected queue.
    always @(posedge CLK) begin
        #1;
        if (RESET && issue_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL issue_unexpected: got %0h expected none", issue_entry);
            end else begin
                chk("issue_entry", issue_entry, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [169:0] e;
        logic [169:0] ea, eb, ec, ed;

        RESET = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
        entry_allocate_issue = 1'b0; entry_issue = '0; busy = '0;
        exe_busyclear_flag = 1'b0; exe_busyclear_reg = '0; exe_stall = 1'b0;
        tick(); tick();
        @(negedge CLK); RESET = 1'b1;
        tick();
        chk("rst_count",    170'(count),        170'(0));
        chk("rst_valid",    170'(issue_valid),  170'(0));
        chk("rst_halt",     170'(issue_halt),   170'(0));
        chk("rst_overflow", 170'(overflow_err), 170'(0));
        chk("rst_entry",    issue_entry,        170'(0));

        // Single flow: visible on the second posedge after allocate.
        e = mk(8'h11, 6'd3, 6'd4);
        exp_q.push_back(e);
        drive_alloc(1'b1, e);
        tick();
        chk("flow_lat1_valid", 170'(issue_valid), 170'(0));
        chk("flow_lat1_count", 170'(count),       170'(1));
        drive_alloc(1'b0, '0);
        tick();
        chk("flow_lat2_valid", 170'(issue_valid), 170'(1));
        chk("flow_lat2_count", 170'(count),       170'(0));

        // Out-of-order: E0 waits on p7, E1 goes first, then bypass wakes E0.
        ea = mk(8'h20, 6'd7, 6'd1);
        eb = mk(8'h21, 6'd2, 6'd5);
        exp_q.push_back(eb);
        exp_q.push_back(ea);
        drive_alloc(1'b1, ea);
        busy = 64'h80;
        tick();
        drive_alloc(1'b1, eb);
        tick();
        chk("ooo_count2", 170'(count),       170'(2));
        chk("ooo_noissue", 170'(issue_valid), 170'(0));
        drive_alloc(1'b0, '0);
        tick();
        chk("ooo_e1_valid", 170'(issue_valid), 170'(1));
        chk("ooo_e1_count", 170'(count),       170'(1));
        @(negedge CLK);
        exe_busyclear_flag = 1'b1;
        exe_busyclear_reg  = 6'd7;
        tick();
        chk("byp_e0_valid", 170'(issue_valid), 170'(1));
        chk("byp_e0_count", 170'(count),       170'(0));
        @(negedge CLK);
        exe_busyclear_flag = 1'b0;
        busy = '0;

        // Backpressure: all entries wait on p10.
        @(negedge CLK); busy = 64'h400;
        for (int i = 0; i < 14; i++) begin
            drive_alloc(1'b1, mk(8'h40 + 8'(i), 6'd10, 6'd10));
            tick();
        end
        chk("bp_count14", 170'(count),      170'(14));
        chk("bp_halt14",  170'(issue_halt), 170'(0));
        drive_alloc(1'b1, mk(8'h4E, 6'd10, 6'd10));
        tick();
        chk("bp_count15", 170'(count),      170'(15));
        chk("bp_halt15",  170'(issue_halt), 170'(1));
        drive_alloc(1'b1, mk(8'h4F, 6'd10, 6'd10));
        tick();
        chk("bp_count16", 170'(count),        170'(16));
        chk("bp_ovf16",   170'(overflow_err), 170'(0));
        drive_alloc(1'b1, mk(8'h50, 6'd10, 6'd10));
        tick();
        chk("bp_count17", 170'(count),        170'(16));
        chk("bp_ovf17",   170'(overflow_err), 170'(1));
        drive_alloc(1'b0, '0);
        FLUSH = 1'b1;
        tick();
        chk("bp_flush_count", 170'(count),        170'(0));
        chk("bp_flush_ovf",   170'(overflow_err), 170'(1));
        @(negedge CLK); FLUSH = 1'b0;
        tick();
        chk("bp_halt_clear", 170'(issue_halt), 170'(0));

        // Asynchronous reset mid-run with 5 entries and an allocate in flight.
        for (int i = 0; i < 5; i++) begin
            drive_alloc(1'b1, mk(8'h60 + 8'(i), 6'd10, 6'd10));
            tick();
        end
        chk("mid_count5", 170'(count), 170'(5));
        @(negedge CLK);
        RESET = 1'b0;
        entry_allocate_issue = 1'b1;
        #1;
        chk("mid_rst_count", 170'(count),        170'(0));
        chk("mid_rst_valid", 170'(issue_valid),  170'(0));
        chk("mid_rst_halt",  170'(issue_halt),   170'(0));
        chk("mid_rst_ovf",   170'(overflow_err), 170'(0));
        tick();
        chk("mid_rst_hold", 170'(count), 170'(0));
        @(negedge CLK);
        RESET = 1'b1;
        entry_allocate_issue = 1'b0;
        busy = '0;

        // Stall: six ready entries parked behind exe_stall, then global STALL.
        @(negedge CLK); exe_stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_alloc(1'b1, mk(8'h70 + 8'(i), 6'd1, 6'd2));
            tick();
        end
        @(negedge CLK);
        entry_allocate_issue = 1'b0;
        STALL = 1'b1;
        exe_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 170'(issue_valid), 170'(0));
            chk("stall_count", 170'(count),       170'(6));
        end
        @(negedge CLK);
        STALL = 1'b0;
        FLUSH = 1'b1;
        entry_allocate_issue = 1'b1;
        entry_issue = mk(8'h7F, 6'd1, 6'd2);
        #1;
        chk("flush_halt", 170'(issue_halt), 170'(1));
        tick();
        chk("flush_count", 170'(count),       170'(0));
        chk("flush_valid", 170'(issue_valid), 170'(0));
        @(negedge CLK);
        FLUSH = 1'b0;
        entry_allocate_issue = 1'b0;

        // Compaction: A..D held behind exe_stall, then drained oldest first.
        ea = mk(8'hA0, 6'd11, 6'd12);
        eb = mk(8'hB0, 6'd13, 6'd14);
        ec = mk(8'hC0, 6'd15, 6'd16);
        ed = mk(8'hD0, 6'd17, 6'd0);
        @(negedge CLK); exe_stall = 1'b1;
        drive_alloc(1'b1, ea); tick();
        drive_alloc(1'b1, eb); tick();
        drive_alloc(1'b1, ec); tick();
        drive_alloc(1'b1, ed); tick();
        drive_alloc(1'b0, '0);
        tick(); tick();
        chk("cmp_hold_count", 170'(count),       170'(4));
        chk("cmp_hold_valid", 170'(issue_valid), 170'(0));
        exp_q.push_back(ea);
        exp_q.push_back(eb);
        exp_q.push_back(ec);
        exp_q.push_back(ed);
        @(negedge CLK); exe_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cmp_valid", 170'(issue_valid), 170'(1));
            chk("cmp_count", 170'(count),       170'(3 - i));
        end
        tick();
        chk("cmp_idle_valid", 170'(issue_valid), 170'(0));

        tick(); tick();
        chk("sb_empty", 170'(exp_q.size()), 170'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
